// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
// Watches a multiplexed seven-segment bus and recovers the BCD value shown on
// each digit. A {dig_sel,seg_in} pattern is accepted only after it has held
// steady for STABLE_CYCLES sampled cycles, so that scan transitions are not
// captured. Each accepted pattern with a one-hot digit select updates that
// digit's slot. A frame pulse is issued once every slot has been refreshed.
module seven_seg_scan_decoder #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   err_out,
   output logic                    sample_valid,
   output logic                    frame_valid
);

   localparam int unsigned SW = NUM_DIGITS + 7;
   localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   state_t                  state;
   logic [SW-1:0]           s_reg;
   logic [CW-1:0]           cnt;
   logic [NUM_DIGITS-1:0]   frame_mask;

   logic [SW-1:0]           cur;
   logic                    match;
   logic [NUM_DIGITS-1:0]   s_sel;
   logic [6:0]              s_seg;
   logic                    sel_onehot;
   logic [3:0]              dec_val;
   logic                    dec_err;
   logic [NUM_DIGITS-1:0]   mask_merged;
   logic                    frame_done;
   logic                    capture;

   assign cur   = {dig_sel, seg_in};
   assign match = (cur == s_reg);
   assign s_sel = s_reg[SW-1:7];
   assign s_seg = s_reg[6:0];

   // Segment pattern to digit value; blank shows F without error.
   always_comb begin
      dec_val = 4'hF;
      dec_err = 1'b0;
      case (s_seg)
         7'h7E:   dec_val = 4'd0;
         7'h30:   dec_val = 4'd1;
         7'h6D:   dec_val = 4'd2;
         7'h79:   dec_val = 4'd3;
         7'h33:   dec_val = 4'd4;
         7'h5B:   dec_val = 4'd5;
         7'h5F:   dec_val = 4'd6;
         7'h70:   dec_val = 4'd7;
         7'h7F:   dec_val = 4'd8;
         7'h7B:   dec_val = 4'd9;
         7'h00:   dec_val = 4'hF;
         default: dec_err = 1'b1;
      endcase
   end

   // Capture qualification and frame-completion detection.
   always_comb begin
      sel_onehot  = $onehot(s_sel);
      capture     = (state == SETTLE) && match && (cnt == CNT_LAST);
      mask_merged = frame_mask | s_sel;
      frame_done  = &mask_merged;
   end

   // Sampling register, stability FSM and registered slot/flag outputs.
   // On the capture edge s_reg already equals the live inputs, so the decode
   // works from s_reg rather than the raw bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         s_reg        <= '0;
         cnt          <= '0;
         frame_mask   <= '0;
         digits_out   <= '0;
         err_out      <= '0;
         sample_valid <= 1'b0;
         frame_valid  <= 1'b0;
      end else begin
         s_reg        <= cur;
         sample_valid <= 1'b0;
         frame_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (!match) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end
            end
            SETTLE: begin
               if (!match) begin
                  cnt <= '0;
               end else if (capture) begin
                  state <= HOLD;
                  cnt   <= CNT_MAX;
                  if (sel_onehot) begin
                     for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (s_sel[i]) begin
                           digits_out[4*i +: 4] <= dec_val;
                           err_out[i]           <= dec_err;
                        end
                     end
                     sample_valid <= 1'b1;
                     if (frame_done) begin
                        frame_valid <= 1'b1;
                        frame_mask  <= '0;
                     end else begin
                        frame_mask  <= mask_merged;
                     end
                  end
               end else if (cnt < CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!match) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Testbench for seven_seg_scan_decoder: directed scenarios plus randomized
// scan traffic. A reference model tracks how long the bus has held its value
// and pushes the expected slot state of every capture into a queue; a monitor
// pops and compares whenever the DUT pulses sample_valid.
module tb_seven_seg_scan_decoder;

   localparam int N = 4;
   localparam int S = 4;
   localparam logic [6:0] SEG_TBL [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                           7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   logic             clk;
   logic             rst;
   logic [6:0]       seg_in;
   logic [N-1:0]     dig_sel;
   logic [4*N-1:0]   digits_out;
   logic [N-1:0]     err_out;
   logic             sample_valid;
   logic             frame_valid;

   seven_seg_scan_decoder #(
      .NUM_DIGITS   (N),
      .STABLE_CYCLES(S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .dig_sel     (dig_sel),
      .digits_out  (digits_out),
      .err_out     (err_out),
      .sample_valid(sample_valid),
      .frame_valid (frame_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int             cyc;
      logic [4*N-1:0] dig;
      logic [N-1:0]   err;
      logic           frame;
   } exp_t;

   exp_t q[$];

   int tests = 0;
   int fails = 0;
   int edge_cnt = 0;
   int sv_count = 0;
   int fv_count = 0;

   // Reference model state
   logic [N+6:0]   last_seen;
   int             run;
   bit             armed;
   logic [4*N-1:0] exp_dig;
   logic [N-1:0]   exp_err;
   logic [N-1:0]   exp_mask;

   function automatic void ref_decode(input logic [6:0] seg, output logic [3:0] v, output logic e);
      v = 4'hF;
      e = (seg != 7'h00);
      for (int k = 0; k < 10; k++) begin
         if (seg == SEG_TBL[k]) begin
            v = k[3:0];
            e = 1'b0;
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference model: a capture happens when a new bus value has been seen on
   // S+1 consecutive edges, once per distinct hold.
   always @(posedge clk) begin
      logic [N+6:0] cur;
      logic [3:0]   v;
      logic         e;
      exp_t         ent;
      edge_cnt++;
      if (rst) begin
         last_seen = '0;
         run       = 0;
         armed     = 0;
         exp_dig   = '0;
         exp_err   = '0;
         exp_mask  = '0;
         q.delete();
      end else begin
         cur = {dig_sel, seg_in};
         if (cur != last_seen) begin
            last_seen = cur;
            run       = 1;
            armed     = 1;
         end else begin
            run++;
         end
         if (armed && run == S + 1) begin
            armed = 0;
            if ($countones(dig_sel) == 1) begin
               ref_decode(seg_in, v, e);
               for (int i = 0; i < N; i++) begin
                  if (dig_sel[i]) begin
                     exp_dig[4*i +: 4] = v;
                     exp_err[i]        = e;
                  end
               end
               exp_mask  = exp_mask | dig_sel;
               ent.frame = (exp_mask == {N{1'b1}});
               if (ent.frame) exp_mask = '0;
               ent.cyc = edge_cnt;
               ent.dig = exp_dig;
               ent.err = exp_err;
               q.push_back(ent);
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT reports a capture.
   always @(negedge clk) begin
      exp_t ent;
      if (frame_valid) fv_count++;
      while (q.size() > 0 && q[0].cyc < edge_cnt) begin
         ent = q.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_capture: no sample_valid for capture expected at edge %0d", ent.cyc);
      end
      if (sample_valid) begin
         sv_count++;
         if (q.size() > 0 && q[0].cyc == edge_cnt) begin
            ent = q.pop_front();
            check("digits_out", 32'(digits_out), 32'(ent.dig));
            check("err_out", 32'(err_out), 32'(ent.err));
            check("frame_valid", 32'(frame_valid), 32'(ent.frame));
         end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_capture: sample_valid=1 at edge %0d, expected 0", edge_cnt);
         end
      end else if (frame_valid) begin
         tests++;
         fails++;
         $display("FAIL frame_without_sample: frame_valid=1 sample_valid=0, expected 0 at edge %0d", edge_cnt);
      end
   end

   // Starting at a rising edge, change the bus 2ns later and hold for n edges.
   task automatic apply(input logic [N-1:0] sel, input logic [6:0] seg, input int n);
      #2;
      dig_sel = sel;
      seg_in  = seg;
      repeat (n) @(posedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_digits"}, 32'(digits_out), 32'd0);
      check({tag, "_err"}, 32'(err_out), 32'd0);
      check({tag, "_sv"}, 32'(sample_valid), 32'd0);
      check({tag, "_fv"}, 32'(frame_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sv0, fv0;
      logic [N-1:0] sel;
      logic [6:0]   seg;
      rst     = 1'b1;
      dig_sel = '0;
      seg_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      #2 rst = 1'b0;
      @(posedge clk);

      // Every legal digit on slot 0
      sv0 = sv_count;
      for (int d = 0; d < 10; d++) apply(4'b0001, SEG_TBL[d], 6);
      check("t2_samples", 32'(sv_count - sv0), 32'd10);
      check("t2_slot0", 32'(digits_out[3:0]), 32'd9);
      check("t2_err0", 32'(err_out[0]), 32'd0);

      // Short glitch is not captured
      sv0 = sv_count;
      apply(4'b0001, 7'h30, 3);
      apply(4'b0001, 7'h6D, 6);
      check("t3_samples", 32'(sv_count - sv0), 32'd1);
      check("t3_slot0", 32'(digits_out[3:0]), 32'd2);

      // Full scan completes a frame on the slot 3 capture
      fv0 = fv_count;
      apply(4'b0001, 7'h30, 6);
      apply(4'b0010, 7'h6D, 6);
      apply(4'b0100, 7'h79, 6);
      check("t4_no_early_frame", 32'(fv_count - fv0), 32'd0);
      apply(4'b1000, 7'h33, 6);
      check("t4_digits", 32'(digits_out), 32'h4321);
      check("t4_frames", 32'(fv_count - fv0), 32'd1);

      // Illegal and blank patterns
      apply(4'b0010, 7'h01, 6);
      check("t5_slot1_bad", 32'(digits_out[7:4]), 32'hF);
      check("t5_err1_bad", 32'(err_out[1]), 32'd1);
      apply(4'b0010, 7'h00, 6);
      check("t5_slot1_blank", 32'(digits_out[7:4]), 32'hF);
      check("t5_err1_blank", 32'(err_out[1]), 32'd0);

      // Non-one-hot selects never capture
      sv0 = sv_count;
      apply(4'b0011, 7'h7E, 10);
      apply(4'b0000, 7'h30, 10);
      check("t6_samples", 32'(sv_count - sv0), 32'd0);
      check("t6_digits", 32'(digits_out), 32'(exp_dig));
      check("t6_err", 32'(err_out), 32'(exp_err));

      // Mid-frame asynchronous reset discards partial progress
      apply(4'b0001, 7'h7E, 6);
      apply(4'b0010, 7'h30, 6);
      apply('0, 7'h00, 1);
      #3 rst = 1'b1;
      #1 check_zero("midreset");
      @(posedge clk);
      @(posedge clk);
      #4 rst = 1'b0;
      @(posedge clk);
      fv0 = fv_count;
      apply(4'b0100, 7'h5B, 6);
      apply(4'b1000, 7'h5F, 6);
      check("t1_no_stale_frame", 32'(fv_count - fv0), 32'd0);
      apply(4'b0001, 7'h70, 6);
      apply(4'b0010, 7'h7F, 6);
      check("t1_fresh_frame", 32'(fv_count - fv0), 32'd1);
      check("t1_digits", 32'(digits_out), 32'h6587);

      // Randomized scan traffic with glitches, blanks, bad patterns, bad selects
      for (int r = 0; r < 400; r++) begin
         int p;
         p = $urandom_range(0, 9);
         if (p < 8) sel = N'(1) << $urandom_range(0, N - 1);
         else       sel = N'($urandom);
         p = $urandom_range(0, 9);
         if (p < 7)       seg = SEG_TBL[$urandom_range(0, 9)];
         else if (p == 7) seg = 7'h00;
         else             seg = 7'($urandom);
         apply(sel, seg, $urandom_range(1, 8));
      end

      apply('0, 7'h00, 8);
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      check("final_digits", 32'(digits_out), 32'(exp_dig));
      check("final_err", 32'(err_out), 32'(exp_err));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
